// File: rtl/jfpjc_pkg.sv
// Shared JPEG-pipeline definitions: quotient buffer geometry and scheduler FSM states.
package jfpjc_pkg;

  localparam int NUM_QUOTIENT_BUFFERS = 4;
  localparam int COEFFS_PER_BLOCK     = 64;

  typedef enum logic [2:0] {
    SCHED_IDLE      = 3'd0,
    SCHED_START     = 3'd1,
    SCHED_WAIT_BUSY = 3'd2,
    SCHED_RUN       = 3'd3,
    SCHED_RELEASE   = 3'd4
  } sched_state_e;

  // A buffer is complete once its last zig-zag coefficient has been written.
  function automatic logic is_fill_done(input logic valid, input logic [7:0] tag);
    return valid && (tag[5:0] == 6'(COEFFS_PER_BLOCK - 1));
  endfunction

endpackage

// File: rtl/quotient_buffer_scheduler_if.sv
// Divider/encoder-side signal bundle of the quotient buffer scheduler.
interface quotient_buffer_scheduler_if;

  logic       quotient_valid;
  logic [7:0] quotient_tag;
  logic       encoder_busy;
  logic       encoder_start;
  logic [1:0] encoder_buffer_sel;
  logic       dc_pred_reset;
  logic [2:0] occupancy;
  logic       producer_stall;
  logic       frame_done;
  logic [1:0] error_flags;

  modport master (
    output quotient_valid, quotient_tag, encoder_busy,
    input  encoder_start, encoder_buffer_sel, dc_pred_reset, occupancy,
           producer_stall, frame_done, error_flags
  );

  modport slave (
    input  quotient_valid, quotient_tag, encoder_busy,
    output encoder_start, encoder_buffer_sel, dc_pred_reset, occupancy,
           producer_stall, frame_done, error_flags
  );

endinterface

// File: rtl/quotient_buffer_scheduler.sv
// Hands filled quotient buffers to the huffman encoder in ring order and tracks frame position.
// Optional macro QUOTIENT_SCHED_OVERFLOW_DETECT_EN enables the sticky overflow flag (error_flags[0]).
//
// state           | meaning
// SCHED_IDLE      | no buffer in flight, waiting for a filled buffer
// SCHED_START     | encoder_start pulse (dc_pred_reset too on MCU 0 of a frame)
// SCHED_WAIT_BUSY | waiting for encoder_busy, retry start on timeout
// SCHED_RUN       | encoder working on encoder_buffer_sel
// SCHED_RELEASE   | buffer freed, read pointer and MCU count advance
module quotient_buffer_scheduler
  import jfpjc_pkg::*;
#(
  parameter int MCUS_PER_FRAME = 1200,
  parameter int BUSY_TIMEOUT   = 15
) (
  input logic                         clock,
  input logic                         nreset,
  quotient_buffer_scheduler_if.slave  bus
);

  localparam int MCU_W = (MCUS_PER_FRAME > 1) ? $clog2(MCUS_PER_FRAME) : 1;
  localparam int TMR_W = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam logic [MCU_W-1:0] MCU_LAST = MCU_W'(MCUS_PER_FRAME - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BUSY_TIMEOUT);
  localparam logic [2:0]       OCC_FULL = 3'(NUM_QUOTIENT_BUFFERS);

  sched_state_e     state_q, state_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       occupancy_q, occupancy_d;
  logic [MCU_W-1:0] mcu_cnt_q, mcu_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_seq_q, err_seq_d;
  logic             frame_done_q, frame_done_d;

  logic fill_done;
  logic release_now;
  logic occ_full;
  logic occ_inc;
  logic err_ovf;

  assign fill_done   = is_fill_done(bus.quotient_valid, bus.quotient_tag);
  assign release_now = (state_q == SCHED_RELEASE);
  assign occ_full    = (occupancy_q == OCC_FULL);
  // A fill at full occupancy only lands if a buffer is freed in the same cycle.
  assign occ_inc     = fill_done && (!occ_full || release_now);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      SCHED_IDLE: begin
        if ((occupancy_q != 3'd0) || fill_done) state_d = SCHED_START;
      end
      SCHED_START: begin
        timer_d = TMR_LOAD;
        state_d = SCHED_WAIT_BUSY;
      end
      SCHED_WAIT_BUSY: begin
        if (bus.encoder_busy) begin
          timer_d = '0;
          state_d = SCHED_RUN;
        end else if (timer_q == '0) begin
          state_d = SCHED_START;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      SCHED_RUN: begin
        if (!bus.encoder_busy) state_d = SCHED_RELEASE;
      end
      SCHED_RELEASE: begin
        state_d = SCHED_IDLE;
      end
      default: begin
        state_d = SCHED_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occupancy_d  = occupancy_q;
    mcu_cnt_d    = mcu_cnt_q;
    err_seq_d    = err_seq_q;
    frame_done_d = 1'b0;

    if (fill_done) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
      if (bus.quotient_tag[7:6] != wr_ptr_q) err_seq_d = 1'b1;
    end

    if (occ_inc && !release_now)      occupancy_d = occupancy_q + 3'd1;
    else if (!occ_inc && release_now) occupancy_d = occupancy_q - 3'd1;

    if (release_now) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
      if (mcu_cnt_q == MCU_LAST) begin
        mcu_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        mcu_cnt_d = mcu_cnt_q + MCU_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= SCHED_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occupancy_q  <= '0;
      mcu_cnt_q    <= '0;
      timer_q      <= '0;
      err_seq_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occupancy_q  <= occupancy_d;
      mcu_cnt_q    <= mcu_cnt_d;
      timer_q      <= timer_d;
      err_seq_q    <= err_seq_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef QUOTIENT_SCHED_OVERFLOW_DETECT_EN
  logic err_ovf_q, err_ovf_d;

  assign err_ovf_d = err_ovf_q | (fill_done & occ_full);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) err_ovf_q <= 1'b0;
    else         err_ovf_q <= err_ovf_d;
  end

  assign err_ovf = err_ovf_q;
`else
  assign err_ovf = 1'b0;
`endif

  assign bus.encoder_start      = (state_q == SCHED_START);
  assign bus.dc_pred_reset      = (state_q == SCHED_START) && (mcu_cnt_q == '0);
  assign bus.encoder_buffer_sel = rd_ptr_q;
  assign bus.occupancy          = occupancy_q;
  assign bus.producer_stall     = occ_full;
  assign bus.frame_done         = frame_done_q;
  assign bus.error_flags        = {err_seq_q, err_ovf};

endmodule

// File: tb/tb_quotient_buffer_scheduler.sv
// Self-checking bench for quotient_buffer_scheduler; expected encoder starts come from a fill-order scoreboard.
module tb_quotient_buffer_scheduler;

  localparam int MPF = 3;
  localparam int BT  = 15;

`ifdef QUOTIENT_SCHED_OVERFLOW_DETECT_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic clock  = 1'b0;
  logic nreset = 1'b0;

  quotient_buffer_scheduler_if bus ();

  quotient_buffer_scheduler #(
    .MCUS_PER_FRAME(MPF),
    .BUSY_TIMEOUT  (BT)
  ) dut (
    .clock (clock),
    .nreset(nreset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // scoreboard entry: {expected encoder_buffer_sel, expected dc_pred_reset}
  logic [2:0] exp_q[$];
  logic [1:0] m_wr;
  int         m_pushed;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    nreset             = 1'b0;
    bus.quotient_valid = 1'b0;
    bus.quotient_tag   = 8'h00;
    bus.encoder_busy   = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
    exp_q.delete();
    m_wr     = 2'd0;
    m_pushed = 0;
    tick();
  endtask

  task automatic fill(input logic [1:0] b, input bit full);
    logic [5:0] idx;
    if (full) begin
      for (int i = 0; i < 64; i++) begin
        idx                = 6'(i);
        bus.quotient_valid = 1'b1;
        bus.quotient_tag   = {b, idx};
        tick();
      end
    end else begin
      bus.quotient_valid = 1'b1;
      bus.quotient_tag   = {b, 6'h3F};
      tick();
    end
    bus.quotient_valid = 1'b0;
    exp_q.push_back({m_wr, 1'((m_pushed % MPF) == 0)});
    m_wr     = m_wr + 2'd1;
    m_pushed = m_pushed + 1;
  endtask

  task automatic wait_start(input int budget, output bit seen);
    int k;
    k = 0;
    while (bus.encoder_start !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    seen = (bus.encoder_start === 1'b1);
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    nreset             = 1'b0;
    bus.quotient_valid = 1'b0;
    bus.quotient_tag   = 8'h00;
    bus.encoder_busy   = 1'b0;
    #2;
    obs = {bus.encoder_start, bus.encoder_buffer_sel, bus.dc_pred_reset, bus.occupancy,
           bus.producer_stall, bus.frame_done, bus.error_flags};
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0", obs);
    end
    do_reset();
  endtask

  task automatic test_single_mcu();
    bit         seen;
    logic [2:0] exp;
    int         k;
    do_reset();
    fill(2'd0, 1'b1);
    wait_start(0, seen);
    exp = exp_q.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL single_start_latency: encoder_start=%b want 1", bus.encoder_start);
    end else if ({bus.encoder_buffer_sel, bus.dc_pred_reset} !== exp) begin
      errors++;
      $display("FAIL single_start_sel_dc: got %b want %b", {bus.encoder_buffer_sel, bus.dc_pred_reset}, exp);
    end
    checks++;
    if (bus.occupancy !== 3'd1) begin
      errors++;
      $display("FAIL single_occ_filled: got %0d want 1", bus.occupancy);
    end
    bus.encoder_busy = 1'b1;
    repeat (10) tick();
    bus.encoder_busy = 1'b0;
    k = 0;
    while (bus.occupancy !== 3'd0 && k < 6) begin
      tick();
      k++;
    end
    checks++;
    if (bus.occupancy !== 3'd0 || bus.encoder_buffer_sel !== 2'd1) begin
      errors++;
      $display("FAIL single_release: occ=%0d sel=%0d want occ=0 sel=1", bus.occupancy, bus.encoder_buffer_sel);
    end
  endtask

  task automatic test_overflow();
    bit         seen;
    logic [2:0] exp;
    do_reset();
    fill(2'd0, 1'b0);
    wait_start(0, seen);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || {bus.encoder_buffer_sel, bus.dc_pred_reset} !== exp) begin
      errors++;
      $display("FAIL ovf_first_start: start=%b sel_dc=%b want 1 %b", bus.encoder_start,
               {bus.encoder_buffer_sel, bus.dc_pred_reset}, exp);
    end
    bus.encoder_busy = 1'b1;
    fill(2'd1, 1'b0);
    fill(2'd2, 1'b0);
    fill(2'd3, 1'b0);
    checks++;
    if (bus.occupancy !== 3'd4 || bus.producer_stall !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full: occ=%0d stall=%b want 4 1", bus.occupancy, bus.producer_stall);
    end
    fill(2'd0, 1'b0);
    checks++;
    if (bus.occupancy !== 3'd4) begin
      errors++;
      $display("FAIL ovf_occ_hold: got %0d want 4", bus.occupancy);
    end
    checks++;
    if (bus.error_flags !== {1'b0, EXP_OVF}) begin
      errors++;
      $display("FAIL ovf_flags: got %b want %b", bus.error_flags, {1'b0, EXP_OVF});
    end
    bus.encoder_busy = 1'b0;
  endtask

  task automatic test_release_collision();
    bit         seen;
    logic [2:0] exp;
    do_reset();
    fill(2'd0, 1'b0);
    wait_start(0, seen);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || {bus.encoder_buffer_sel, bus.dc_pred_reset} !== exp) begin
      errors++;
      $display("FAIL coll_first_start: start=%b sel_dc=%b want 1 %b", bus.encoder_start,
               {bus.encoder_buffer_sel, bus.dc_pred_reset}, exp);
    end
    bus.encoder_busy = 1'b1;
    repeat (4) tick();
    bus.encoder_busy = 1'b0;
    tick();
    fill(2'd1, 1'b0);
    checks++;
    if (bus.occupancy !== 3'd1 || bus.encoder_buffer_sel !== 2'd1) begin
      errors++;
      $display("FAIL coll_occ: occ=%0d sel=%0d want 1 1", bus.occupancy, bus.encoder_buffer_sel);
    end
    wait_start(3, seen);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || {bus.encoder_buffer_sel, bus.dc_pred_reset} !== exp) begin
      errors++;
      $display("FAIL coll_next_start: start=%b sel_dc=%b want 1 %b", bus.encoder_start,
               {bus.encoder_buffer_sel, bus.dc_pred_reset}, exp);
    end
  endtask

  task automatic test_seq_error();
    bit         seen;
    logic [2:0] exp;
    do_reset();
    fill(2'd1, 1'b0);
    checks++;
    if (bus.error_flags !== 2'b10 || bus.occupancy !== 3'd1) begin
      errors++;
      $display("FAIL seq_err: flags=%b occ=%0d want 10 1", bus.error_flags, bus.occupancy);
    end
    wait_start(0, seen);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || {bus.encoder_buffer_sel, bus.dc_pred_reset} !== exp) begin
      errors++;
      $display("FAIL seq_start: start=%b sel_dc=%b want 1 %b", bus.encoder_start,
               {bus.encoder_buffer_sel, bus.dc_pred_reset}, exp);
    end
  endtask

  task automatic test_frame();
    bit         seen;
    logic [2:0] exp;
    int         fd;
    int         k;
    do_reset();
    for (int m = 0; m < 4; m++) begin
      fill(2'(m), 1'b0);
      wait_start(0, seen);
      exp = exp_q.pop_front();
      checks++;
      if (!seen || {bus.encoder_buffer_sel, bus.dc_pred_reset} !== exp) begin
        errors++;
        $display("FAIL frame_start_%0d: start=%b sel_dc=%b want 1 %b", m, bus.encoder_start,
                 {bus.encoder_buffer_sel, bus.dc_pred_reset}, exp);
      end
      bus.encoder_busy = 1'b1;
      repeat (3) tick();
      bus.encoder_busy = 1'b0;
      fd = 0;
      k  = 0;
      while (k < 6) begin
        tick();
        k++;
        if (bus.frame_done === 1'b1) fd++;
        if (bus.occupancy === 3'd0) break;
      end
      checks++;
      if (fd != ((m == 2) ? 1 : 0)) begin
        errors++;
        $display("FAIL frame_done_%0d: pulses=%0d want %0d", m, fd, (m == 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_timeout_reset();
    bit         seen;
    logic [2:0] exp;
    logic [10:0] obs;
    int         k;
    bit         bad;
    do_reset();
    fill(2'd0, 1'b0);
    wait_start(0, seen);
    exp = exp_q.pop_front();
    checks++;
    if (!seen || {bus.encoder_buffer_sel, bus.dc_pred_reset} !== exp) begin
      errors++;
      $display("FAIL tmo_first_start: start=%b sel_dc=%b want 1 %b", bus.encoder_start,
               {bus.encoder_buffer_sel, bus.dc_pred_reset}, exp);
    end
    for (int r = 0; r < 2; r++) begin
      k = 0;
      do begin
        tick();
        k++;
      end while (bus.encoder_start !== 1'b1 && k < 40);
      checks++;
      if (k != 17 || bus.encoder_start !== 1'b1 || bus.encoder_buffer_sel !== 2'd0) begin
        errors++;
        $display("FAIL tmo_retry_%0d: period=%0d start=%b sel=%0d want 17 1 0", r, k,
                 bus.encoder_start, bus.encoder_buffer_sel);
      end
    end
    bus.encoder_busy = 1'b1;
    repeat (3) tick();
    nreset = 1'b0;
    #1;
    obs = {bus.encoder_start, bus.encoder_buffer_sel, bus.dc_pred_reset, bus.occupancy,
           bus.producer_stall, bus.frame_done, bus.error_flags};
    checks++;
    if (obs !== 11'd0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got %b want 0", obs);
    end
    bus.encoder_busy = 1'b0;
    #2;
    nreset = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      tick();
      if (bus.frame_done !== 1'b0 || bus.encoder_start !== 1'b0 || bus.occupancy !== 3'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrun_after_reset: activity seen, want none (fd=%b start=%b occ=%0d)",
               bus.frame_done, bus.encoder_start, bus.occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_single_mcu();
    test_overflow();
    test_release_collision();
    test_seq_error();
    test_frame();
    test_timeout_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quotient_buffer_scheduler.md
QUOTIENT_BUFFER_SCHEDULER -- requirements
Module: quotient_buffer_scheduler

Interface
REQ-001 SHALL have parameter MCUS_PER_FRAME, default 1200, meaning MCUs per frame (320x240 / 64).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 15, meaning cycles to wait for encoder busy to rise after start.
REQ-003 SHALL have port clock, input, 1, the single clock.
REQ-004 SHALL have port nreset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port quotient_valid, input, 1, divider wrote one coefficient this cycle.
REQ-006 SHALL have port quotient_tag, input, 8, {buffer[1:0], zig-zag index[5:0]} of that write.
REQ-007 SHALL have port encoder_busy, input, 1, huffman encoder busy.
REQ-008 SHALL have port encoder_start, output, 1, one-cycle start pulse to the encoder.
REQ-009 SHALL have port encoder_buffer_sel, output, 2, buffer the encoder reads.
REQ-010 SHALL have port dc_pred_reset, output, 1, one-cycle pulse to clear the encoder DC predictor.
REQ-011 SHALL have port occupancy, output, 3, filled-but-unencoded buffers, range 0..4.
REQ-012 SHALL have port producer_stall, output, 1, high when occupancy==4.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse after the last MCU of a frame is encoded.
REQ-014 SHALL have port error_flags, output, 2, sticky flags: [0] overflow, [1] sequence error.

Function
REQ-015 SHALL treat a fill as complete when quotient_valid is 1 and quotient_tag[5:0]==63; the filled buffer is quotient_tag[7:6].
REQ-016 SHALL keep wr_ptr[1:0], increment it on each fill completion, and wrap 3->0.
REQ-017 SHALL set error_flags[1] when a fill completes with quotient_tag[7:6] != wr_ptr; the fill still counts.
REQ-018 SHALL run FSM states IDLE, START, WAIT_BUSY, RUN, RELEASE.
- IDLE -> START when occupancy>0.
- START: encoder_start=1 for exactly one cycle, then -> WAIT_BUSY.
- WAIT_BUSY -> RUN when encoder_busy=1.
- WAIT_BUSY -> START (retry) after BUSY_TIMEOUT cycles without encoder_busy.
- RUN -> RELEASE when encoder_busy=0.
- RELEASE: one cycle, rd_ptr+1, occupancy-1, -> IDLE.
REQ-019 SHALL drive encoder_buffer_sel = rd_ptr, held constant from START through RELEASE.
REQ-020 SHALL assert dc_pred_reset in the same cycle as encoder_start when that MCU is index 0 of a frame.
REQ-021 SHALL give minimum latency of 1 cycle from the fill-completion cycle to encoder_start, with FSM in IDLE.
REQ-022 SHALL leave occupancy unchanged when a fill completion and RELEASE occur in the same cycle.
REQ-023 SHALL NOT increment occupancy beyond 4 when a fill completes at occupancy==4; occupancy holds and wr_ptr still advances.
REQ-024 SHALL count encoded MCUs 0..MCUS_PER_FRAME-1, increment in RELEASE, and wrap to 0.
REQ-025 SHALL pulse frame_done in the cycle after the RELEASE that wraps the MCU counter.
REQ-026 SHALL derive producer_stall combinationally from registered occupancy.

Reset
REQ-027 SHALL on nreset=0, asynchronously: FSM=IDLE, wr_ptr=rd_ptr=0, occupancy=0, MCU count=0, timeout counter=0, error_flags=0, encoder_start=0, dc_pred_reset=0, frame_done=0, encoder_buffer_sel=0, producer_stall=0.
REQ-028 SHALL abandon any in-flight MCU on reset mid-RUN; no frame_done and no RELEASE follow.

Configuration
REQ-029 SHALL, with QUOTIENT_SCHED_OVERFLOW_DETECT_EN defined, set error_flags[0] on a fill completion while occupancy==4.
REQ-030 SHALL, without QUOTIENT_SCHED_OVERFLOW_DETECT_EN, tie error_flags[0] to 0 and synthesize no detection logic; all other behaviour is identical.

Structure
REQ-031 SHALL take from shared package jfpjc_pkg: the FSM state enum, NUM_QUOTIENT_BUFFERS=4, and COEFFS_PER_BLOCK=64.
REQ-032 SHALL be a single module with no sub-module; the occupancy/pointer ring is inline.

Verification
REQ-033 Single MCU: tags 0x00..0x3F -> encoder_start 1 cycle after tag 0x3F, sel=0, dc_pred_reset=1; encoder busy for 10 cycles -> occupancy 1->0, rd_ptr=1.
REQ-034 Fill 4 buffers, busy held high -> occupancy=4 and producer_stall=1; 5th fill -> error_flags[0]=1 with macro defined, 0 without; occupancy stays 4.
REQ-035 Fill completion in the RELEASE cycle -> occupancy unchanged, next encoder_start follows.
REQ-036 Fill with tag 0x7F while wr_ptr=0 -> error_flags[1]=1.
REQ-037 MCUS_PER_FRAME=3, 4 MCUs -> frame_done after the 3rd RELEASE; dc_pred_reset on the 1st and 4th starts.
REQ-038 busy never rises, BUSY_TIMEOUT=15 -> encoder_start re-pulses every 17 cycles, same sel; nreset pulse mid-RUN -> all outputs 0 immediately.
